// File: rtl/buffer_rr_arbiter.sv
// Round-robin arbiter feeding a single-entry holding stage with configurable
// forward (accept -> out_valid) and backward (handshake -> next grant) latency.
module buffer_rr_arbiter #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int FL    = 2,
   parameter int BL    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N-1:0]           in_valid,
   input  logic [N*WIDTH-1:0]     in_data,
   output logic [N-1:0]           in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [$clog2(N)-1:0]   out_src,
   output logic                   busy
);

   localparam int         SW      = $clog2(N);
   localparam logic [7:0] FL_C    = 8'(FL);
   localparam logic [7:0] BL_C    = 8'(BL);
   localparam bit         FL_ZERO = (FL == 0);
   localparam bit         BL_ZERO = (BL == 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      SEND = 2'd2,
      BACK = 2'd3
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [7:0]          cnt_r, cnt_nxt_s;
   logic [SW-1:0]       ptr_r;
   logic                out_valid_r, out_valid_nxt_s;
   logic                busy_r, busy_nxt_s;
   logic [WIDTH-1:0]    out_data_r;
   logic [SW-1:0]       out_src_r;
   logic [SW:0]         grant_s;
   logic                grant_found_s;
   logic [SW-1:0]       grant_idx_s;
   logic [N-1:0]        in_ready_s;
   logic                accept_s;

   // Scan from the highest offset down so the lowest offset from ptr wins.
   function automatic logic [SW:0] pick_grant(input logic [N-1:0] valid,
                                               input logic [SW-1:0] ptr);
      logic [SW:0] res;
      int          j;
      res = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (valid[j]) begin
            res = {1'b1, SW'(j)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Grant selection and the combinational ready, gated low during reset.
   always_comb begin
      grant_s       = pick_grant(in_valid, ptr_r);
      grant_found_s = grant_s[SW];
      grant_idx_s   = grant_s[SW-1:0];
      in_ready_s    = (rst_n && (state_r == IDLE) && grant_found_s)
                      ? (N'(1) << grant_idx_s) : {N{1'b0}};
      accept_s      = |(in_valid & in_ready_s);
   end

   // Next-state and latency counter.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (!accept_s) begin
               state_nxt_s = IDLE;
            end else if (FL_ZERO) begin
               state_nxt_s = SEND;
               cnt_nxt_s   = 8'd0;
            end else begin
               state_nxt_s = FWD;
               cnt_nxt_s   = FL_C;
            end
         end
         FWD: begin
            if (cnt_r == 8'd1) begin
               state_nxt_s = SEND;
               cnt_nxt_s   = 8'd0;
            end else begin
               cnt_nxt_s   = cnt_r - 8'd1;
            end
         end
         SEND: begin
            if (!out_ready) begin
               state_nxt_s = SEND;
            end else if (BL_ZERO) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 8'd0;
            end else begin
               state_nxt_s = BACK;
               cnt_nxt_s   = BL_C;
            end
         end
         BACK: begin
            if (cnt_r == 8'd1) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 8'd0;
            end else begin
               cnt_nxt_s   = cnt_r - 8'd1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 8'd0;
         end
      endcase
   end

   // Registered output decode is taken from the next state.
   always_comb begin
      out_valid_nxt_s = (state_nxt_s == SEND);
      busy_nxt_s      = (state_nxt_s != IDLE);
   end

   // State, counter, pointer and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= 8'd0;
         ptr_r       <= '0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         out_data_r  <= '0;
         out_src_r   <= '0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         busy_r      <= busy_nxt_s;
         if (accept_s) begin
            out_data_r <= in_data[grant_idx_s*WIDTH +: WIDTH];
            out_src_r  <= grant_idx_s;
            ptr_r      <= (grant_idx_s == SW'(N - 1)) ? '0 : grant_idx_s + SW'(1);
         end else begin
            out_data_r <= out_data_r;
            out_src_r  <= out_src_r;
            ptr_r      <= ptr_r;
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign out_data  = out_data_r;
   assign out_src   = out_src_r;

endmodule

// File: tb/tb_buffer_rr_arbiter.sv
// Bench for buffer_rr_arbiter: an FL=BL=2 instance checked against a
// timestamp-based reference model, plus an FL=BL=0 instance.
module tb_buffer_rr_arbiter;

   localparam int W   = 8;
   localparam int N   = 4;
   localparam int FLA = 2;
   localparam int BLA = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   in_valid = '0, in_ready;
   logic [N*W-1:0] in_data = '0;
   logic           out_valid, out_ready = 1'b0, busy;
   logic [W-1:0]   out_data;
   logic [1:0]     out_src;

   logic [N-1:0]   z_in_valid = '0, z_in_ready;
   logic [N*W-1:0] z_in_data = '0;
   logic           z_out_valid, z_out_ready = 1'b0, z_busy;
   logic [W-1:0]   z_out_data;
   logic [1:0]     z_out_src;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: holding flag plus accept / release edge timestamps.
   int           cyc = 0;
   int           m_free = 0;
   int           m_acc = 0;
   int           m_ptr = 0;
   int           m_src = 0;
   bit           m_hold = 1'b0;
   logic [W-1:0] m_data = '0;
   logic [N-1:0] exp_ready;
   bit           exp_ov, exp_busy, exp_accept;
   int           exp_g;

   buffer_rr_arbiter #(.WIDTH(W), .N(N), .FL(FLA), .BL(BLA)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_src(out_src), .busy(busy));

   buffer_rr_arbiter #(.WIDTH(W), .N(N), .FL(0), .BL(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .in_valid(z_in_valid), .in_data(z_in_data),
      .in_ready(z_in_ready), .out_valid(z_out_valid), .out_ready(z_out_ready),
      .out_data(z_out_data), .out_src(z_out_src), .busy(z_busy));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_eval();
      bit idle, found;
      int j;
      idle  = !m_hold && (cyc >= m_free);
      found = 1'b0;
      exp_g = 0;
      for (int k = 0; k < N; k++) begin
         j = (m_ptr + k) % N;
         if (!found && in_valid[j]) begin
            found = 1'b1;
            exp_g = j;
         end
      end
      exp_accept = idle && found;
      exp_ready  = exp_accept ? (4'b0001 << exp_g) : 4'b0000;
      exp_ov     = m_hold && (cyc >= m_acc + FLA);
      exp_busy   = !idle;
   endtask

   task automatic model_advance();
      cyc++;
      if (exp_accept) begin
         m_hold = 1'b1;
         m_acc  = cyc;
         m_data = in_data[exp_g*W +: W];
         m_src  = exp_g;
         m_ptr  = (exp_g + 1) % N;
      end else if (exp_ov && out_ready) begin
         m_hold = 1'b0;
         m_free = cyc + BLA;
      end
   endtask

   task automatic model_reset();
      m_hold = 1'b0;
      m_ptr  = 0;
      m_free = 0;
   endtask

   task automatic tick();
      model_eval();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #10;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic drain();
      in_valid  = '0;
      out_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         model_eval();
         if (!exp_busy) break;
         tick();
      end
      model_eval();
      tests_run++;
      if (busy !== 1'b0 || exp_busy) begin
         tests_failed++;
         $display("FAIL drain_idle: busy=%0b required 0", busy);
      end
   endtask

   task automatic test_reset();
      in_valid = 4'b1111;
      in_data  = $urandom;
      #1;
      tests_run += 5;
      if (in_ready !== 4'b0000) begin tests_failed++; $display("FAIL rst_in_ready: got %b required 0000", in_ready); end
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b required 0", busy); end
      if (out_src !== 2'd0) begin tests_failed++; $display("FAIL rst_out_src: got %0d required 0", out_src); end
      if (out_data !== 8'h00) begin tests_failed++; $display("FAIL rst_out_data: got %h required 00", out_data); end
      rst_n = 1'b1;
      model_reset();
      in_valid = 4'b0010;
      in_data[1*W +: W] = 8'h3C;
      #1;
      tests_run++;
      if (in_ready !== 4'b0010) begin tests_failed++; $display("FAIL rst_first_grant: got %b required 0010", in_ready); end
      tick();
      in_valid = 4'b1111;
      for (int k = 0; k < 10; k++) begin
         model_eval();
         if (exp_ov) break;
         tick();
      end
      #1;
      tests_run += 3;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL pre_rst_send: got %b required 1", out_valid); end
      if (out_src !== 2'd1) begin tests_failed++; $display("FAIL pre_rst_src: got %0d required 1", out_src); end
      if (out_data !== 8'h3C) begin tests_failed++; $display("FAIL pre_rst_data: got %h required 3c", out_data); end
      rst_n = 1'b0;
      #1;
      tests_run += 4;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); end
      if (in_ready !== 4'b0000) begin tests_failed++; $display("FAIL mid_rst_in_ready: got %b required 0000", in_ready); end
      if (out_src !== 2'd0) begin tests_failed++; $display("FAIL mid_rst_out_src: got %0d required 0", out_src); end
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      #1;
      tests_run++;
      if (in_ready !== 4'b0001) begin tests_failed++; $display("FAIL post_rst_grant: got %b required 0001", in_ready); end
   endtask

   task automatic test_single_latency();
      logic [5:0] ov_tab;
      ov_tab = 6'b000100;
      drain();
      in_valid = 4'b0100;
      in_data[2*W +: W] = 8'hA5;
      out_ready = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 4'b0100) begin tests_failed++; $display("FAIL lat_grant: got %b required 0100", in_ready); end
      tick();
      for (int k = 0; k <= 5; k++) begin
         tests_run += 3;
         if (out_valid !== ov_tab[k]) begin tests_failed++; $display("FAIL lat_out_valid[E0+%0d]: got %b required %b", k, out_valid, ov_tab[k]); end
         if (in_ready !== ((k == 5) ? 4'b0100 : 4'b0000)) begin tests_failed++; $display("FAIL lat_in_ready[E0+%0d]: got %b", k, in_ready); end
         if (busy !== (k != 5)) begin tests_failed++; $display("FAIL lat_busy[E0+%0d]: got %b", k, busy); end
         if (k == 2) begin
            tests_run += 2;
            if (out_data !== 8'hA5) begin tests_failed++; $display("FAIL lat_data: got %h required a5", out_data); end
            if (out_src !== 2'd2) begin tests_failed++; $display("FAIL lat_src: got %0d required 2", out_src); end
         end
         if (k < 5) tick();
      end
      in_valid = '0;
   endtask

   task automatic test_fairness();
      int got;
      do_reset();
      in_valid = 4'b1111;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
      out_ready = 1'b1;
      got = 0;
      for (int k = 0; k < 100 && got < 8; k++) begin
         model_eval();
         tests_run++;
         if (out_valid !== exp_ov) begin tests_failed++; $display("FAIL fair_out_valid: got %b required %b", out_valid, exp_ov); end
         if (exp_ov) begin
            tests_run += 2;
            if (out_src !== 2'(got % 4)) begin tests_failed++; $display("FAIL fair_order[%0d]: got %0d required %0d", got, out_src, got % 4); end
            if (out_data !== 8'h10 + 8'(got % 4)) begin tests_failed++; $display("FAIL fair_data[%0d]: got %h", got, out_data); end
            got++;
         end
         tick();
      end
      tests_run++;
      if (got != 8) begin tests_failed++; $display("FAIL fair_timeout: got %0d items required 8", got); end
      drain();
   endtask

   task automatic test_skip_wrap();
      do_reset();
      in_valid = 4'b0001;
      out_ready = 1'b1;
      #1;
      tick();
      drain();
      in_valid = 4'b1001;
      #1;
      tests_run++;
      if (in_ready !== 4'b1000) begin tests_failed++; $display("FAIL skip_first: got %b required 1000", in_ready); end
      tick();
      for (int k = 0; k < 30; k++) begin
         model_eval();
         if (exp_accept) break;
         tick();
      end
      tests_run++;
      if (in_ready !== 4'b0001) begin tests_failed++; $display("FAIL wrap_second: got %b required 0001", in_ready); end
      tick();
      drain();
      in_valid = 4'b1111;
      #1;
      tests_run++;
      if (in_ready !== 4'b0010) begin tests_failed++; $display("FAIL wrap_ptr: got %b required 0010", in_ready); end
      in_valid = '0;
   endtask

   task automatic test_backpressure();
      drain();
      in_valid  = 4'b1111;
      in_data   = $urandom;
      out_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         model_eval();
         if (exp_ov) break;
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         if (k == 5) out_ready = 1'b1;
         #1;
         tests_run += 4;
         if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_out_valid[%0d]: got %b required 1", k, out_valid); end
         if (out_data !== m_data) begin tests_failed++; $display("FAIL bp_data[%0d]: got %h required %h", k, out_data, m_data); end
         if (out_src !== 2'(m_src)) begin tests_failed++; $display("FAIL bp_src[%0d]: got %0d required %0d", k, out_src, m_src); end
         if (in_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_in_ready[%0d]: got %b required 0000", k, in_ready); end
         tick();
      end
      for (int k = 0; k < BLA; k++) begin
         tests_run += 3;
         if (busy !== 1'b1) begin tests_failed++; $display("FAIL bp_back_busy[%0d]: got %b required 1", k, busy); end
         if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_back_ov[%0d]: got %b required 0", k, out_valid); end
         if (in_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_back_ready[%0d]: got %b required 0000", k, in_ready); end
         tick();
      end
      model_eval();
      tests_run += 2;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_idle_busy: got %b required 0", busy); end
      if (in_ready !== exp_ready || exp_ready == 4'b0000) begin tests_failed++; $display("FAIL bp_idle_ready: got %b required %b", in_ready, exp_ready); end
      in_valid = '0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         model_eval();
         tests_run += 3;
         if (in_ready !== exp_ready) begin tests_failed++; $display("FAIL rnd_in_ready@%0d: got %b required %b", k, in_ready, exp_ready); end
         if (out_valid !== exp_ov) begin tests_failed++; $display("FAIL rnd_out_valid@%0d: got %b required %b", k, out_valid, exp_ov); end
         if (busy !== exp_busy) begin tests_failed++; $display("FAIL rnd_busy@%0d: got %b required %b", k, busy, exp_busy); end
         if (exp_ov) begin
            tests_run += 2;
            if (out_data !== m_data) begin tests_failed++; $display("FAIL rnd_data@%0d: got %h required %h", k, out_data, m_data); end
            if (out_src !== 2'(m_src)) begin tests_failed++; $display("FAIL rnd_src@%0d: got %0d required %0d", k, out_src, m_src); end
         end
         tick();
      end
      drain();
   endtask

   task automatic test_zero_latency();
      logic [W-1:0] z_exp;
      int items;
      z_exp = '0;
      items = 0;
      z_in_valid  = 4'b0001;
      z_out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         z_in_data = $urandom;
         #1;
         tests_run += 3;
         if (z_in_ready !== ((k % 2 == 0) ? 4'b0001 : 4'b0000)) begin tests_failed++; $display("FAIL zl_in_ready[%0d]: got %b", k, z_in_ready); end
         if (z_out_valid !== (k % 2 == 1)) begin tests_failed++; $display("FAIL zl_out_valid[%0d]: got %b", k, z_out_valid); end
         if (z_busy !== (k % 2 == 1)) begin tests_failed++; $display("FAIL zl_busy[%0d]: got %b", k, z_busy); end
         if (k % 2 == 1) begin
            tests_run += 2;
            if (z_out_data !== z_exp) begin tests_failed++; $display("FAIL zl_data[%0d]: got %h required %h", k, z_out_data, z_exp); end
            if (z_out_src !== 2'd0) begin tests_failed++; $display("FAIL zl_src[%0d]: got %0d required 0", k, z_out_src); end
            items++;
         end else begin
            z_exp = z_in_data[W-1:0];
         end
         tick();
      end
      tests_run++;
      if (items != 6) begin tests_failed++; $display("FAIL zl_items: got %0d required 6", items); end
      z_in_valid = '0;
   endtask

   initial begin
      @(posedge clk);
      @(posedge clk);
      #1;
      test_reset();
      test_single_latency();
      test_fairness();
      test_skip_wrap();
      test_backpressure();
      test_random();
      test_zero_latency();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/buffer_rr_arbiter.md
# buffer_rr_arbiter

Clocked round-robin arbiter that shares one buffer stage among `N` requester channels. It runs a single-entry holding register through the stage's receive, forward-latency, send and backward-latency phases, with the forward and backward latencies counted in cycles. Sits between several producer channels and one downstream consumer channel and tags each forwarded item with its source index.

## Interface
- `WIDTH`, 8: data width in bits.
- `N`, 4: number of requester channels; legal range 2..16.
- `FL`, 2: forward latency in cycles, accept to `out_valid`; legal range 0..255.
- `BL`, 2: backward latency in cycles, output handshake to next `in_ready`; legal range 0..255.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  N  per-requester valid; bit i belongs to requester i.
- `in_data`  in  N*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`  out  N  one-hot grant, or all zero.
- `out_valid`  out  1  held item available downstream.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  held item.
- `out_src`  out  $clog2(N)  index of the requester that supplied the held item.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States are IDLE, FWD, SEND and BACK. An 8-bit down-counter `cnt` and a rotating priority pointer `ptr` (0..N-1) are kept alongside the state.
- IDLE
  - Grant g is the first index with `in_valid` set, scanning ptr, ptr+1, …, wrapping mod N.
  - `in_ready` is one-hot at g, combinational from `in_valid`, state and ptr. It is all zero when no requester is valid.
  - On an edge where `in_valid[g] & in_ready[g]`: capture `in_data[g]` into `out_data` and g into `out_src`, and set ptr <= (g+1) mod N.
  - After that edge: state <= FWD with cnt <= FL if FL>0, otherwise state <= SEND.
- FWD
  - `in_ready` is all zero.
  - When cnt==1, go to SEND; otherwise cnt <= cnt-1.
- SEND
  - `out_valid`=1; `out_data` and `out_src` are stable.
  - On an edge with `out_ready`=1: state <= BACK with cnt <= BL if BL>0, otherwise state <= IDLE.
- BACK
  - `in_ready` is all zero.
  - When cnt==1, go to IDLE; otherwise cnt <= cnt-1.
- `out_valid` is 1 only in SEND. `in_ready` is nonzero only in IDLE.
- The grant is recomputed every IDLE cycle. If a valid requester drops `in_valid` before it is accepted, nothing is committed and ptr is unchanged.
- ptr changes only on an input acceptance.

## Timing
- Reset (asynchronous, while `rst_n`=0) forces:
  - state=IDLE, ptr=0, cnt=0;
  - `out_valid`=0, `out_data`=0, `out_src`=0, `busy`=0;
  - `in_ready`=0, which is forced low combinationally while reset is asserted.
- Reset mid-operation discards the held item and produces no output handshake. The first grant after release goes to the lowest valid index starting from 0.
- Accept on edge E0: `out_valid` rises at edge E0+FL (at E0 when FL=0).
- Output handshake on edge H: `in_ready` may assert from edge H+BL (immediately after H when BL=0).
- Minimum period per item is FL+BL+2 cycles; with FL=BL=0 it is 2 cycles.
- `out_valid`/`out_ready` simultaneous with new `in_valid` activity: no overlap is possible, because input and output handshakes never occur in the same cycle.
- Wrap-around: when g=N-1, ptr becomes 0.
- `busy` is a registered decode of state and is 0 exactly in IDLE.

## Test plan
- Reset values: assert `rst_n`=0 mid-SEND with `in_valid`=4'b1111 → `out_valid`=0, `in_ready`=0, `out_src`=0 and `busy`=0 immediately. After release, first grant goes to requester 0.
- Single-item latency: FL=2, BL=2; requester 2 sends 8'hA5 at edge E0, `out_ready`=1.
  - `out_valid` rises at E0+2 with `out_data`=8'hA5 and `out_src`=2.
  - The handshake occurs at E0+3, and `in_ready` reasserts at E0+5.
- Fairness: all four requesters valid continuously, sending 8'h10+i → output order by `out_src` is 0,1,2,3,0,1,2,3. No requester is granted twice before every other valid requester has been granted once.
- Skip and wrap: ptr=1, only requesters 3 and 0 valid → 3 is granted first (ptr becomes 0), then 0 (ptr becomes 1).
- Backpressure: hold `out_ready`=0 for 5 cycles in SEND → `out_valid`=1, `out_data` and `out_src` stay constant, and `in_ready` stays 0 throughout. The handshake on the 6th cycle is followed by BL cycles of BACK.
- Zero latency: FL=0, BL=0, one requester always valid, `out_ready`=1 → one item every 2 cycles, with `out_valid` high in alternate cycles.
